// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Operands in and result out through valid/ready handshakes; the result holds until accepted.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         b_out
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   r_sr;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic           d_bit;
  logic           borrow_next;
  logic [N-1:0]   r_next;

  assign d_bit       = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign r_next      = {d_bit, r_sr[N-1:1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            r_sr   <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= r_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the completed word including the bit computed this edge.
          if (cnt == CW'(N - 1)) begin
            diff  <= r_next;
            b_out <= borrow_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (N = 8): results, latency,
// backpressure, busy-ignore and asynchronous reset abort.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       b_out;

  int n_vec  = 0;
  int n_fail = 0;

  serial_subtractor #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] ed;
    logic       eb;
    int         stall;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One transaction; inject > 0 pulses in_valid with junk operands on that BUSY cycle.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                       input logic [7:0] ed, input logic eb, input int stall, input int inject);
    int cycles;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    a = oa; b = ob; b_in = obin; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == inject) begin
        a = 8'd99; b = 8'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("latency", cycles, 8);
    check("diff", diff, ed);
    check("b_out", b_out, eb);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_diff", diff, ed);
      check("stall_b_out", b_out, eb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_drop", out_valid, 0);
    check("in_ready_idle", in_ready, 1);
    check("diff_kept", diff, ed);
    $display("op a=%0d b=%0d b_in=%0d -> diff=%0d b_out=%0d (exp %0d/%0d) lat=%0d stall=%0d",
             oa, ob, obin, diff, b_out, ed, eb, cycles, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ref9;
    logic [7:0] ra, rb;
    logic       rbin;

    tbl[0] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 0};
    tbl[1] = '{8'd64,  8'd1,   1'b0, 8'd63,  1'b0, 0};
    tbl[2] = '{8'd16,  8'd12,  1'b1, 8'd3,   1'b0, 0};
    tbl[3] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 0};
    tbl[4] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 0};
    tbl[5] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 0};
    tbl[6] = '{8'd96,  8'd0,   1'b1, 8'd95,  1'b0, 0};
    tbl[7] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0, 5};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; b_in = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_b_out", b_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].va, tbl[i].vb, tbl[i].vbin, tbl[i].ed, tbl[i].eb, tbl[i].stall, 0);

    // Busy-ignore: second operands offered mid-computation must not be captured.
    do_op(8'd10, 8'd3, 1'b0, 8'd7, 1'b0, 0, 2);
    repeat (3) @(negedge clk);
    check("busy_ignore_no_restart", in_ready, 1);

    // Reset abort at BUSY bit 4; previous diff of 7 must be cleared.
    @(negedge clk);
    a = 8'd200; b = 8'd1; b_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_diff", diff, 0);
    check("abort_b_out", b_out, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_result", out_valid, 0);
    do_op(8'd5, 8'd9, 1'b0, 8'd252, 1'b1, 0, 0);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      do_op(ra, rb, rbin, ref9[7:0], ref9[8], $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
